// File: rtl/uart_prog_pkg.sv
// Shared types and frame constants for the UART cartridge loader.
package uart_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_H,
    ADDR_L,
    LEN,
    DATA,
    WRITE,
    CKSUM
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_PRG   = 8'h01;
  localparam logic [7:0] CMD_CHR   = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;

endpackage

// File: rtl/uart_byte_capture.sv
// Edge-detects uart_rx byte-valid, holds one byte with a pending flag and flags overrun.
module uart_byte_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  logic       consume_i,
  input  logic       err_clr_i,
  output logic [7:0] byte_o,
  output logic       pend_o,
  output logic       err_overrun_o
);

  logic       valid_q;
  logic [7:0] hold_q, hold_d;
  logic       pend_q, pend_d;
  logic       ovr_q, ovr_d;
  logic       rise;

  assign rise = valid_i & ~valid_q;

  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q & ~consume_i;
    ovr_d  = ovr_q & ~err_clr_i;
    if (rise) begin
      // The slot counts as free if the FSM is draining it this same cycle.
      if (pend_q && !consume_i) begin
        ovr_d = 1'b1;
      end else begin
        hold_d = data_i;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign byte_o        = hold_q;
  assign pend_o        = pend_q;
  assign err_overrun_o = ovr_q;

endmodule

// File: rtl/uart_prog_ctrl.sv
// Frame sequencer turning UART bytes into PRG/CHR memory writes and console hold control.
// Optional frame checksum enabled by defining UART_PROG_CKSUM_EN.
module uart_prog_ctrl
  import uart_prog_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 65535,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_valid,
  input  logic [7:0]        uart_DI,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              cpu_hold,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout,
  output logic              err_cksum
);

  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [7:0]        data_q, data_d;
  logic              sel_q, sel_d;
  logic              hold_q, hold_d;
  logic              etmo_q, etmo_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              consume, err_clr, pend;
  logic [7:0]        rx_byte;
`ifdef UART_PROG_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        cmd_q, cmd_d;
  logic              eck_q, eck_d;
`endif

  uart_byte_capture u_cap (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (uart_valid),
    .data_i       (uart_DI),
    .consume_i    (consume),
    .err_clr_i    (err_clr),
    .byte_o       (rx_byte),
    .pend_o       (pend),
    .err_overrun_o(err_overrun)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    etmo_d  = etmo_q;
    tmo_d   = tmo_q;
    consume = 1'b0;
    err_clr = 1'b0;
`ifdef UART_PROG_CKSUM_EN
    sum_d   = sum_q;
    cmd_d   = cmd_q;
    eck_d   = eck_q;
    if (pend && state_q != IDLE && state_q != WRITE) sum_d = sum_q + rx_byte;
`endif
    case (state_q)
      IDLE: if (pend) begin
        consume = 1'b1;
        if (rx_byte == SYNC_BYTE) begin
          state_d = CMD;
          err_clr = 1'b1;
          etmo_d  = 1'b0;
`ifdef UART_PROG_CKSUM_EN
          eck_d   = 1'b0;
          sum_d   = '0;
`endif
        end
      end
      CMD: if (pend) begin
        consume = 1'b1;
`ifdef UART_PROG_CKSUM_EN
        cmd_d   = rx_byte;
`endif
        case (rx_byte)
          CMD_PRG, CMD_CHR: begin
            sel_d   = (rx_byte == CMD_CHR);
            state_d = ADDR_H;
          end
`ifdef UART_PROG_CKSUM_EN
          CMD_RUN, CMD_HALT: state_d = CKSUM;
`else
          CMD_RUN, CMD_HALT: begin
            hold_d  = (rx_byte == CMD_HALT);
            state_d = IDLE;
          end
`endif
          default: state_d = IDLE;
        endcase
      end
      ADDR_H: if (pend) begin
        consume = 1'b1;
        addr_d  = ADDR_W'({rx_byte, 8'h00});
        state_d = ADDR_L;
      end
      ADDR_L: if (pend) begin
        consume = 1'b1;
        addr_d  = addr_q | ADDR_W'(rx_byte);
        state_d = LEN;
      end
      LEN: if (pend) begin
        consume = 1'b1;
        rem_d   = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
        state_d = DATA;
      end
      DATA: if (pend) begin
        consume = 1'b1;
        data_d  = rx_byte;
        state_d = WRITE;
      end
      WRITE: if (mem_ready) begin
        addr_d = addr_q + ADDR_W'(1);
        rem_d  = rem_q - 9'd1;
        if (rem_q == 9'd1) begin
`ifdef UART_PROG_CKSUM_EN
          state_d = CKSUM;
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_PROG_CKSUM_EN
      CKSUM: if (pend) begin
        consume = 1'b1;
        state_d = IDLE;
        if (sum_d == 8'h00) begin
          if (cmd_q == CMD_RUN)  hold_d = 1'b0;
          if (cmd_q == CMD_HALT) hold_d = 1'b1;
        end else begin
          eck_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Inter-byte timer: frozen while a write is stalled, reset by every consumed byte.
    if (state_q == IDLE || consume) begin
      tmo_d = '0;
    end else if (state_q != WRITE) begin
      if (tmo_q == TW'(TIMEOUT_CLKS)) begin
        tmo_d   = '0;
        state_d = IDLE;
        etmo_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      sel_q   <= 1'b0;
      hold_q  <= 1'b1;
      etmo_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      etmo_q  <= etmo_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef UART_PROG_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cmd_q <= '0;
      eck_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cmd_q <= cmd_d;
      eck_q <= eck_d;
    end
  end
  assign err_cksum = eck_q;
`else
  assign err_cksum = 1'b0;
`endif

  assign mem_we      = (state_q == WRITE);
  assign mem_sel     = sel_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign cpu_hold    = hold_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = etmo_q;

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Directed self-checking bench for uart_prog_ctrl (short timeout for simulation speed).
module tb_uart_prog_ctrl;

  localparam int unsigned TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_valid = 1'b0;
  logic [7:0]  uart_DI = 8'h00;
  logic        mem_we, mem_sel, mem_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_hold, busy, err_overrun, err_timeout, err_cksum;

  int checks = 0;
  int failures = 0;

  // Memory responder: 0 = always ready, 1 = ready after 10 stalled clocks, 2 = never ready
  int          mode = 0;
  int          wait_cnt = 0;
  int          wr_cnt = 0;
  logic [15:0] wr_a [64];
  logic [7:0]  wr_d [64];
  logic        wr_s [64];
  int          wr_w [64];
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] held_a;
  logic [7:0]  held_d;
  byte unsigned fq[$];

  uart_prog_ctrl #(.TIMEOUT_CLKS(TMO), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_valid (uart_valid),
    .uart_DI    (uart_DI),
    .mem_we     (mem_we),
    .mem_sel    (mem_sel),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .err_cksum  (err_cksum)
  );

  always #5 clk = ~clk;

  initial mem_ready = 1'b1;

  always @(negedge clk) begin
    if (mem_we) wait_cnt = wait_cnt + 1;
    else        wait_cnt = 0;
    mem_ready = (mode == 0) || (mode == 1 && wait_cnt > 10);
    if (mem_we && mem_ready) begin
      if (wr_cnt < 64) begin
        wr_a[wr_cnt] = mem_addr;
        wr_d[wr_cnt] = mem_data;
        wr_s[wr_cnt] = mem_sel;
        wr_w[wr_cnt] = wait_cnt;
      end
      wr_cnt   = wr_cnt + 1;
      wait_cnt = 0;
    end
    if (mem_we && !mem_ready) begin
      if (prev_stall && (mem_addr !== held_a || mem_data !== held_d)) hold_viol = hold_viol + 1;
      held_a     = mem_addr;
      held_d     = mem_data;
      prev_stall = 1'b1;
    end else begin
      if (prev_stall && !mem_we && rst_n) hold_viol = hold_viol + 1;
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    uart_valid = 1'b1;
    uart_DI    = b;
    repeat (4) @(posedge clk);
    #1 uart_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Sends fq; with checksum enabled, appends the byte making CMD..CK sum to zero.
  task automatic send_frame();
    logic [7:0] s;
    s = 8'h00;
    foreach (fq[i]) begin
      send_byte(fq[i]);
      if (i > 0) s = s + fq[i];
    end
`ifdef UART_PROG_CKSUM_EN
    send_byte(8'h00 - s);
`endif
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_we !== 1'b0)    begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_sel !== 1'b0)   begin failures++; $display("FAIL reset_mem_sel got=%b exp=0", mem_sel); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_data !== 8'h0)  begin failures++; $display("FAIL reset_mem_data got=%h exp=00", mem_data); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cpu_hold !== 1'b1)  begin failures++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if ({err_overrun, err_timeout, err_cksum} !== 3'b000) begin
      failures++; $display("FAIL reset_errors got=%b exp=000", {err_overrun, err_timeout, err_cksum});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b1)  begin failures++; $display("FAIL post_reset_cpu_hold got=%b exp=1", cpu_hold); end
  endtask

  task automatic test_run_halt();
    fq = '{8'hA5, 8'h03};
    send_frame();
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL run_cpu_hold got=%b exp=0", cpu_hold); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL run_busy got=%b exp=0", busy); end
    fq = '{8'hA5, 8'h04};
    send_frame();
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL halt_cpu_hold got=%b exp=1", cpu_hold); end
  endtask

  task automatic test_prg_write();
    int base;
    logic [15:0] ea [3];
    logic [7:0]  ed [3];
    ea = '{16'h8000, 16'h8001, 16'h8002};
    ed = '{8'h11, 8'h22, 8'h33};
    mode = 0;
    base = wr_cnt;
    fq = '{8'hA5, 8'h01, 8'h80, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frame();
    checks++; if (wr_cnt - base != 3) begin failures++; $display("FAIL prg_count got=%0d exp=3", wr_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_a[base+i] !== ea[i] || wr_d[base+i] !== ed[i] || wr_s[base+i] !== 1'b0) begin
        failures++;
        $display("FAIL prg_write%0d got=%b:%h=%h exp=0:%h=%h", i, wr_s[base+i], wr_a[base+i], wr_d[base+i], ea[i], ed[i]);
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prg_busy got=%b exp=0", busy); end
    checks++; if ({err_overrun, err_timeout, err_cksum} !== 3'b000) begin
      failures++; $display("FAIL prg_errors got=%b exp=000", {err_overrun, err_timeout, err_cksum});
    end
  endtask

  task automatic test_chr_wrap_stall();
    int base;
    mode = 1;
    base = wr_cnt;
    hold_viol = 0;
    fq = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB};
    send_frame();
    repeat (30) @(posedge clk);
    #1;
    checks++; if (wr_cnt - base != 2) begin failures++; $display("FAIL chr_count got=%0d exp=2", wr_cnt - base); end
    checks++; if (wr_a[base] !== 16'hFFFF || wr_d[base] !== 8'hAA || wr_s[base] !== 1'b1) begin
      failures++; $display("FAIL chr_write0 got=%b:%h=%h exp=1:ffff=aa", wr_s[base], wr_a[base], wr_d[base]);
    end
    checks++; if (wr_a[base+1] !== 16'h0000 || wr_d[base+1] !== 8'hBB || wr_s[base+1] !== 1'b1) begin
      failures++; $display("FAIL chr_wrap got=%b:%h=%h exp=1:0000=bb", wr_s[base+1], wr_a[base+1], wr_d[base+1]);
    end
    checks++; if (wr_w[base] != 11 || wr_w[base+1] != 11) begin
      failures++; $display("FAIL chr_we_held got=%0d,%0d exp=11,11", wr_w[base], wr_w[base+1]);
    end
    checks++; if (hold_viol != 0) begin failures++; $display("FAIL chr_stable_during_stall got=%0d exp=0", hold_viol); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL chr_busy got=%b exp=0", busy); end
    mode = 0;
  endtask

  task automatic test_timeout();
    int base;
    base = wr_cnt;
    fq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h04};
    foreach (fq[i]) send_byte(fq[i]);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_busy_before got=%b exp=1", busy); end
    repeat (TMO + 20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL tmo_busy got=%b exp=0", busy); end
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_flag got=%b exp=1", err_timeout); end
    checks++; if (wr_cnt != base)       begin failures++; $display("FAIL tmo_no_writes got=%0d exp=0", wr_cnt - base); end
    checks++; if (cpu_hold !== 1'b1)    begin failures++; $display("FAIL tmo_cpu_hold got=%b exp=1", cpu_hold); end
    send_byte(8'hA5);
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", err_timeout); end
    send_byte(8'h04);
`ifdef UART_PROG_CKSUM_EN
    send_byte(8'hFC);
`endif
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tmo_recover_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    int base;
    mode = 2;
    base = wr_cnt;
    fq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h5A, 8'h6B, 8'h7C};
    foreach (fq[i]) send_byte(fq[i]);
    checks++; if (err_overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", err_overrun); end
    checks++; if (mem_we !== 1'b1)      begin failures++; $display("FAIL ovr_we_stalled got=%b exp=1", mem_we); end
    mode = 0;
    repeat (10) @(posedge clk);
`ifdef UART_PROG_CKSUM_EN
    send_byte(8'h00 - (8'h01 + 8'h02 + 8'h5A + 8'h6B));
`endif
    #1;
    checks++; if (wr_cnt - base != 2) begin failures++; $display("FAIL ovr_count got=%0d exp=2", wr_cnt - base); end
    checks++; if (wr_a[base] !== 16'h0000 || wr_d[base] !== 8'h5A) begin
      failures++; $display("FAIL ovr_write0 got=%h=%h exp=0000=5a", wr_a[base], wr_d[base]);
    end
    checks++; if (wr_a[base+1] !== 16'h0001 || wr_d[base+1] !== 8'h6B) begin
      failures++; $display("FAIL ovr_write1 got=%h=%h exp=0001=6b", wr_a[base+1], wr_d[base+1]);
    end
    checks++; if (err_cksum !== 1'b0) begin failures++; $display("FAIL ovr_cksum got=%b exp=0", err_cksum); end
    send_byte(8'hA5);
    send_byte(8'h00);
    #1;
    checks++; if (err_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", err_overrun); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL bad_cmd_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midframe();
    int base;
    mode = 2;
    fq = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h77};
    foreach (fq[i]) send_byte(fq[i]);
    base = wr_cnt;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_we_before got=%b exp=1", mem_we); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_async_drop got=we%b busy%b exp=we0 busy0", mem_we, busy);
    end
    mode = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (wr_cnt != base || busy !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL mid_after got=writes%0d busy%b hold%b exp=writes0 busy0 hold1", wr_cnt - base, busy, cpu_hold);
    end
  endtask

`ifdef UART_PROG_CKSUM_EN
  task automatic test_cksum();
    int base;
    base = wr_cnt;
    fq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01, 8'h55, 8'h00};
    foreach (fq[i]) send_byte(fq[i]);
    #1;
    checks++; if (wr_cnt - base != 1 || wr_a[base] !== 16'h0010 || wr_d[base] !== 8'h55) begin
      failures++; $display("FAIL ck_write got=%0d %h=%h exp=1 0010=55", wr_cnt - base, wr_a[base], wr_d[base]);
    end
    checks++; if (err_cksum !== 1'b1) begin failures++; $display("FAIL ck_bad got=%b exp=1", err_cksum); end
    fq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h01, 8'h55, 8'h99};
    foreach (fq[i]) send_byte(fq[i]);
    #1;
    checks++; if (err_cksum !== 1'b0) begin failures++; $display("FAIL ck_good got=%b exp=0", err_cksum); end
    fq = '{8'hA5, 8'h03, 8'h00};
    foreach (fq[i]) send_byte(fq[i]);
    #1;
    checks++; if (cpu_hold !== 1'b1 || err_cksum !== 1'b1) begin
      failures++; $display("FAIL ck_run_bad got=hold%b ck%b exp=hold1 ck1", cpu_hold, err_cksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_halt();
    test_prg_write();
    test_chr_wrap_stall();
    test_timeout();
    test_overrun();
    test_reset_midframe();
`ifdef UART_PROG_CKSUM_EN
    test_cksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
